// File: rtl/vedic_dot_acc.sv
`default_nettype none
// ============================================================================
// vedic_dot_acc : valid/ready dot-product accumulator for 16-bit products.
// Macro VEDIC_ACC_SAT_EN clamps the sum on overflow instead of wrapping.
// Revision: 1.0
// ============================================================================
module vedic_dot_acc #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 16,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] c_max_len = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_beat;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_beat    = in_valid && in_ready;
  assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(in_prod);
  assign w_cnt_inc = r_count + c_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_beat) w_state_nxt = (in_last || (MAX_LEN == 1)) ? S_HOLD : S_ACC;
      S_ACC:  if (w_beat) w_state_nxt = (in_last || (w_cnt_inc == c_max_len)) ? S_HOLD : S_ACC;
      S_HOLD: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort wins over any beat or result handshake in the same cycle.
    if (clr) w_state_nxt = S_IDLE;
  end

  always_comb begin
    in_ready  = (r_state != S_HOLD) && rst_n;
    out_valid = (r_state == S_HOLD);
  end

  always_comb begin
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    if (clr) begin
      w_acc_nxt   = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            w_acc_nxt   = ACC_W'(in_prod);
            w_count_nxt = c_one;
            w_ovf_nxt   = 1'b0;
          end
        end
        S_ACC: begin
          if (w_beat) begin
            w_count_nxt = w_cnt_inc;
            if (w_sum[ACC_W]) w_ovf_nxt = 1'b1;
`ifdef VEDIC_ACC_SAT_EN
            w_acc_nxt = (w_sum[ACC_W] || r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
            w_acc_nxt = w_sum[ACC_W-1:0];
`endif
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: begin
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vedic_dot_acc.sv
`default_nettype none
// ============================================================================
// tb_vedic_dot_acc : directed bench with a sum-level model, two widths (24/17).
// Revision: 1.0
// ============================================================================
module tb_vedic_dot_acc;

  localparam int MAXL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        u0_in_ready, u0_out_valid, u0_out_ovf;
  logic [23:0] u0_out_acc;
  logic [4:0]  u0_out_count;
  logic        u1_in_ready, u1_out_valid, u1_out_ovf;
  logic [16:0] u1_out_acc;
  logic [4:0]  u1_out_count;

  int total = 0;
  int bad   = 0;

  longint m_sum  = 0;
  int     m_cnt  = 0;
  bit     m_hold = 1'b0;

  always #5 clk = ~clk;

  vedic_dot_acc #(.ACC_W(24), .MAX_LEN(MAXL)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(u0_in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(u0_out_valid), .out_ready(out_ready),
    .out_acc(u0_out_acc), .out_count(u0_out_count), .out_ovf(u0_out_ovf)
  );

  vedic_dot_acc #(.ACC_W(17), .MAX_LEN(MAXL)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(u1_in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(u1_out_valid), .out_ready(out_ready),
    .out_acc(u1_out_acc), .out_count(u1_out_count), .out_ovf(u1_out_ovf)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected accumulator from the ideal (unbounded) sum of the current vector.
  function automatic longint exp_acc(input int w);
    longint lim;
    lim = longint'(1) << w;
    if (m_sum < lim) return m_sum;
`ifdef VEDIC_ACC_SAT_EN
    return lim - 1;
`else
    return m_sum % lim;
`endif
  endfunction

  function automatic longint exp_ovf(input int w);
    return (m_sum >= (longint'(1) << w)) ? 1 : 0;
  endfunction

  task automatic monitor();
    forever begin
      @(posedge clk);
      if (!rst_n || clr) begin
        m_sum = 0; m_cnt = 0; m_hold = 1'b0;
      end else if (m_hold) begin
        if (out_ready) begin
          m_sum = 0; m_cnt = 0; m_hold = 1'b0;
        end
      end else if (in_valid) begin
        m_sum = m_sum + longint'(in_prod);
        m_cnt = m_cnt + 1;
        if (in_last || m_cnt == MAXL) m_hold = 1'b1;
      end
      #1;
      chk("u0_in_ready",  u0_in_ready,  (!m_hold && rst_n) ? 1 : 0);
      chk("u0_out_valid", u0_out_valid, m_hold ? 1 : 0);
      chk("u0_out_acc",   u0_out_acc,   exp_acc(24));
      chk("u0_out_count", u0_out_count, m_cnt);
      chk("u0_out_ovf",   u0_out_ovf,   exp_ovf(24));
      chk("u1_in_ready",  u1_in_ready,  (!m_hold && rst_n) ? 1 : 0);
      chk("u1_out_valid", u1_out_valid, m_hold ? 1 : 0);
      chk("u1_out_acc",   u1_out_acc,   exp_acc(17));
      chk("u1_out_count", u1_out_count, m_cnt);
      chk("u1_out_ovf",   u1_out_ovf,   exp_ovf(17));
    end
  endtask

  // Present a beat at a negedge and return just after the accepting posedge.
  task automatic beat(input logic [15:0] p, input logic l);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_prod = p; in_last = l;
    n = 0;
    while (!u0_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat_wait", (n < 20) ? 1 : 0, 1);
    @(posedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("lit_ready_after_consume", u0_in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("lit_rst_valid", u0_out_valid, 0);
    chk("lit_rst_acc",   u0_out_acc,   0);
    chk("lit_rst_count", u0_out_count, 0);
    chk("lit_rst_ovf",   u0_out_ovf,   0);
    rst_n = 1'b1;
    #1 chk("lit_rst_ready", u0_in_ready, 1);

    // Single beat with last
    beat(16'h1234, 1'b1);
    #1;
    chk("lit_single_valid", u0_out_valid, 1);
    chk("lit_single_acc",   u0_out_acc,   24'h001234);
    chk("lit_single_count", u0_out_count, 1);
    chk("lit_single_ovf",   u0_out_ovf,   0);
    chk("lit_single_ready", u0_in_ready,  0);
    consume();

    // Three beats of 0xFE01; 17-bit instance overflows on the third
    beat(16'hFE01, 1'b0);
    beat(16'hFE01, 1'b0);
    beat(16'hFE01, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("lit_three_acc",   u0_out_acc,   24'h02FA03);
      chk("lit_three_count", u0_out_count, 3);
      chk("lit_three_ready", u0_in_ready,  0);
      chk("lit_three_ovf",   u0_out_ovf,   0);
    end
`ifdef VEDIC_ACC_SAT_EN
    chk("lit_w17_acc", u1_out_acc, 17'h1FFFF);
`else
    chk("lit_w17_acc", u1_out_acc, 17'h0FA03);
`endif
    chk("lit_w17_ovf", u1_out_ovf, 1);
    consume();

    // Length limit without in_last
    for (int i = 0; i < MAXL; i++) beat(16'h0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("lit_max_valid", u0_out_valid, 1);
    chk("lit_max_acc",   u0_out_acc,   16);
    chk("lit_max_count", u0_out_count, 16);
    // 17th beat waits out the HOLD, then starts a fresh vector
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_prod = 16'h0001; in_last = 1'b1;
    @(negedge clk);
    chk("lit_17th_ready", u0_in_ready, 1);
    @(posedge clk); #1;
    chk("lit_17th_acc",   u0_out_acc,   1);
    chk("lit_17th_count", u0_out_count, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Abort with a colliding beat
    beat(16'h0007, 1'b0);
    beat(16'h0009, 1'b0);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_prod = 16'hFFFF; in_last = 1'b1;
    @(posedge clk); #1;
    chk("lit_clr_valid", u0_out_valid, 0);
    chk("lit_clr_acc",   u0_out_acc,   0);
    chk("lit_clr_count", u0_out_count, 0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    beat(16'h0005, 1'b1);
    #1;
    chk("lit_after_clr_acc",   u0_out_acc,   5);
    chk("lit_after_clr_count", u0_out_count, 1);
    consume();

    // Asynchronous reset in the middle of a vector
    beat(16'h0003, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("lit_async_count", u0_out_count, 0);
    chk("lit_async_acc",   u0_out_acc,   0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(16'h0002, 1'b1);
    #1;
    chk("lit_post_rst_acc",   u0_out_acc,   2);
    chk("lit_post_rst_count", u0_out_count, 1);
    consume();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
